// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the byte-serial memory arbiter: FSM encodings, access
// lengths and small helpers used by the datapath.
package mem_arbiter_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IF_RD  = 3'd1;
    localparam logic [2:0] ST_MEM_RD = 3'd2;
    localparam logic [2:0] ST_MEM_WR = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b11;

    localparam logic [2:0] FETCH_BYTES = 3'd4;

    // 2'b10 is not a legal encoding but is served as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = data;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline request ports (IF fetch, MEM data) plus the byte-wide RAM port.
// Handshake: a requester raises req with stable fields and holds them until
// its done pulse; done is a single-cycle strobe, data is held until the next.
interface mem_arbiter_if #(parameter int RAM_ADDR_W = 17) ();

    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_flush;
    logic                  if_done;
    logic [31:0]           if_inst;

    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [1:0]            mem_len;
    logic [31:0]           mem_wdata;
    logic                  mem_done;
    logic [31:0]           mem_rdata;

    logic                  stallreq_if;
    logic                  stallreq_mem;

    logic [RAM_ADDR_W-1:0] ram_a;
    logic                  ram_wr;
    logic [7:0]            ram_dout;
    logic [7:0]            ram_din;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        input  ram_din,
        output if_done, if_inst, mem_done, mem_rdata,
        output stallreq_if, stallreq_mem,
        output ram_a, ram_wr, ram_dout
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        output ram_din,
        input  if_done, if_inst, mem_done, mem_rdata,
        input  stallreq_if, stallreq_mem,
        input  ram_a, ram_wr, ram_dout
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM between instruction fetch and data
// access, serialising each request into little-endian byte cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_ADDR_W = 17
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic [2:0]   dbg_state
);

    logic [2:0]            state;
    logic [2:0]            cnt;
    logic [2:0]            nbytes;
    logic [RAM_ADDR_W-1:0] base;
    logic [31:0]           wdata_q;
    logic [31:0]           asm_q;

    logic                  if_done_q;
    logic                  mem_done_q;
    logic [31:0]           if_inst_q;
    logic [31:0]           mem_rdata_q;
    logic [RAM_ADDR_W-1:0] ram_a_q;
    logic                  ram_wr_q;
    logic [7:0]            ram_dout_q;

    logic [RAM_ADDR_W-1:0] byte_addr;
    logic [7:0]            wr_byte;
    logic [31:0]           asm_cap;
    logic                  addr_phase;
    logic                  cap_phase;
    logic                  last_cap;
    logic                  unused_addr_bits;

    // cnt counts edges since acceptance: address byte cnt goes out at the end
    // of cycle cnt, and the byte addressed two cycles earlier is on ram_din.
    assign byte_addr  = base + RAM_ADDR_W'(cnt);
    assign wr_byte    = wdata_q[{cnt[1:0], 3'b000} +: 8];
    assign asm_cap    = merge_byte(asm_q, cnt[1:0] - 2'd2, bus.ram_din);
    assign addr_phase = (cnt < nbytes);
    assign cap_phase  = (cnt >= 3'd2);
    assign last_cap   = (cnt == nbytes + 3'd1);

    assign unused_addr_bits = ^{bus.if_addr[31:RAM_ADDR_W], bus.mem_addr[31:RAM_ADDR_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 3'd0;
            nbytes      <= 3'd0;
            base        <= '0;
            wdata_q     <= 32'd0;
            asm_q       <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
        end else begin
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt   <= 3'd0;
                    asm_q <= 32'd0;
                    if (bus.mem_req) begin
                        base    <= bus.mem_addr[RAM_ADDR_W-1:0];
                        nbytes  <= len_bytes(bus.mem_len);
                        wdata_q <= bus.mem_wdata;
                        state   <= bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
                    end else if (bus.if_req && !bus.if_flush) begin
                        base   <= bus.if_addr[RAM_ADDR_W-1:0];
                        nbytes <= FETCH_BYTES;
                        state  <= ST_IF_RD;
                    end
                end

                ST_IF_RD, ST_MEM_RD: begin
                    if (state == ST_IF_RD && bus.if_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (addr_phase)
                            ram_a_q <= byte_addr;
                        if (cap_phase)
                            asm_q <= asm_cap;
                        if (last_cap) begin
                            state <= ST_DONE;
                            if (state == ST_IF_RD) begin
                                if_done_q <= 1'b1;
                                if_inst_q <= asm_cap;
                            end else begin
                                mem_done_q  <= 1'b1;
                                mem_rdata_q <= asm_cap;
                            end
                        end
                    end
                end

                ST_MEM_WR: begin
                    if (addr_phase) begin
                        ram_a_q    <= byte_addr;
                        ram_wr_q   <= 1'b1;
                        ram_dout_q <= wr_byte;
                        cnt        <= cnt + 3'd1;
                    end else begin
                        mem_done_q <= 1'b1;
                        state      <= ST_DONE;
                    end
                end

                // One dead cycle lets the served requester drop req unseen.
                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_done      = if_done_q;
    assign bus.if_inst      = if_inst_q;
    assign bus.mem_done     = mem_done_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.ram_a        = ram_a_q;
    assign bus.ram_wr       = ram_wr_q;
    assign bus.ram_dout     = ram_dout_q;
    assign bus.stallreq_if  = bus.if_req & ~if_done_q;
    assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, fetch/data drivers, and a scoreboard
// fed from a flat byte-image reference of memory contents.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;
  localparam int MASK  = DEPTH - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  mem_arbiter_if #(.RAM_ADDR_W(AW)) bus();

  mem_arbiter #(.RAM_ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [7:0]  ram    [DEPTH];
  logic [7:0]  shadow [DEPTH];
  logic [31:0] exp_q     [$];
  logic [32:0] exp_mem_q [$];
  int          chk_addr_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          illegal_wr = 0;
  int          stall_err  = 0;
  bit          store_active = 1'b0;
  logic [31:0] last_if = 32'd0;
  logic [32:0] mon_e;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event seen, none required", name);
  endfunction

  function automatic int len_n(logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr, int n);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = shadow[int'(addr + 32'(i)) & MASK];
    return v;
  endfunction

  // synchronous byte RAM: read data appears the cycle after its address
  initial begin
    for (int a = 0; a < DEPTH; a++) ram[a] = 8'($urandom);
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05;
    ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h20]  = 8'hFF;
    ram[32'h1FFFF] = 8'h34; ram[32'h0] = 8'h12;
    bus.ram_din = 8'd0;
    forever begin
      @(posedge clk);
      if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
      bus.ram_din <= ram[bus.ram_a];
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_done) begin
        if (exp_q.size() == 0) fail_now("if_done_unexpected");
        else check("if_inst", bus.if_inst, exp_q.pop_front());
      end
      if (bus.mem_done) begin
        if (exp_mem_q.size() == 0) fail_now("mem_done_unexpected");
        else begin
          mon_e = exp_mem_q.pop_front();
          if (!mon_e[32]) check("mem_rdata", bus.mem_rdata, mon_e[31:0]);
        end
      end
      if (bus.ram_wr && !store_active) illegal_wr++;
      if (bus.stallreq_if !== (bus.if_req & ~bus.if_done)) stall_err++;
      if (bus.stallreq_mem !== (bus.mem_req & ~bus.mem_done)) stall_err++;
    end
  end

  // driver tasks
  task automatic fetch_txn(input logic [31:0] addr, input int exp_lat, input bit chk_a);
    logic [31:0] e;
    int n;
    e = model_read(addr, 4);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.if_req = 1'b1;
    bus.if_addr = addr;
    n = -1;
    forever begin
      @(posedge clk); n++;
      @(negedge clk);
      if (chk_a && n >= 1 && n <= 4)
        check("fetch_ram_a", 32'(bus.ram_a), (addr + 32'(n - 1)) & MASK);
      if (bus.if_done) break;
      if (n >= 80) begin
        check("fetch_timeout_done", 32'(bus.if_done), 32'd1);
        break;
      end
    end
    if (exp_lat >= 0) check("fetch_latency", 32'(n), 32'(exp_lat));
    last_if = e;
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic mem_txn(input bit we, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wdata, input int exp_lat, input bit chk_a);
    int n;
    int nb;
    nb = len_n(len);
    if (we) begin
      for (int i = 0; i < nb; i++) begin
        shadow[int'(addr + 32'(i)) & MASK] = wdata[8*i +: 8];
        chk_addr_q.push_back(int'(addr + 32'(i)) & MASK);
      end
      exp_mem_q.push_back({1'b1, 32'd0});
      store_active = 1'b1;
    end else begin
      exp_mem_q.push_back({1'b0, model_read(addr, nb)});
    end
    @(posedge clk); #1;
    bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = addr;
    bus.mem_len = len; bus.mem_wdata = wdata;
    n = -1;
    forever begin
      @(posedge clk); n++;
      @(negedge clk);
      if (chk_a && n >= 1 && n <= nb) begin
        check("mem_ram_a", 32'(bus.ram_a), (addr + 32'(n - 1)) & MASK);
        check("mem_ram_wr", 32'(bus.ram_wr), 32'(we));
        if (we) check("mem_ram_dout", 32'(bus.ram_dout), 32'(wdata[8*(n-1) +: 8]));
      end
      if (bus.mem_done) break;
      if (n >= 80) begin
        check("mem_timeout_done", 32'(bus.mem_done), 32'd1);
        break;
      end
    end
    if (exp_lat >= 0) check("mem_latency", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
    bus.mem_req = 1'b0;
    store_active = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    bit          we;
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = 32'd0;
    bus.mem_len = 2'b00; bus.mem_wdata = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_if_done", 32'(bus.if_done), 32'd0);
    check("rst_mem_done", 32'(bus.mem_done), 32'd0);
    check("rst_if_inst", bus.if_inst, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    check("rst_ram_a", 32'(bus.ram_a), 32'd0);
    check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) shadow[a] = ram[a];

    // word fetch, store word, then simultaneous requests
    fetch_txn(32'h100, 6, 1'b1);
    check("fetch_0x100_value", last_if, 32'h00000513);
    mem_txn(1'b1, 32'h40, LEN_WORD, 32'hDEADBEEF, 5, 1'b1);
    fork
      fetch_txn(32'h300, 11, 1'b0);
      mem_txn(1'b0, 32'h20, LEN_BYTE, 32'd0, 3, 1'b1);
    join

    // flush in cycle 2 of a fetch, then flush+req held in IDLE
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h150;
    repeat (3) @(posedge clk);
    #1 bus.if_flush = 1'b1;
    @(posedge clk); @(negedge clk);
    check("flush_to_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); @(negedge clk);
    check("flush_req_not_accepted", 32'(dbg_state), 32'(ST_IDLE));
    bus.if_req = 1'b0; bus.if_flush = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("flush_if_inst_held", bus.if_inst, last_if);
    fetch_txn(32'h200, 6, 1'b1);

    // half load wrapping past the top of RAM
    mem_txn(1'b0, 32'h1FFFF, LEN_HALF, 32'd0, 4, 1'b1);

    // reset in cycle 2 of a word store: bytes 0 and 1 land, 2 and 3 do not
    store_active = 1'b1;
    shadow[32'h60] = 8'h44; shadow[32'h61] = 8'h33;
    for (int i = 0; i < 4; i++) chk_addr_q.push_back(32'h60 + i);
    @(posedge clk); #1;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h60;
    bus.mem_len = LEN_WORD; bus.mem_wdata = 32'h11223344;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; bus.mem_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("midrst_ram_a", 32'(bus.ram_a), 32'd0);
    check("midrst_mem_done", 32'(bus.mem_done), 32'd0);
    check("midrst_if_inst", bus.if_inst, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    store_active = 1'b0;
    last_if = 32'd0;

    // randomized traffic: stores stay in the upper half, fetches in the lower
    fork
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          fetch_txn(32'($urandom_range(0, 32'hFFF0)), -1, 1'b0);
        end
      end
      begin
        repeat (40) begin
          we  = 1'($urandom_range(0, 1));
          len = 2'($urandom_range(0, 3));
          addr = we ? 32'($urandom_range(32'h10000, 32'h1FFFC))
                    : 32'($urandom_range(0, 32'h1FFFF));
          wdata = $urandom;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          mem_txn(we, addr, len, wdata, -1, 1'b0);
        end
      end
    join

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("if_queue_drained", 32'(exp_q.size()), 32'd0);
    check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
    check("illegal_ram_wr", 32'(illegal_wr), 32'd0);
    check("stallreq", 32'(stall_err), 32'd0);
    foreach (chk_addr_q[i])
      check("ram_byte", 32'(ram[chk_addr_q[i]]), 32'(shadow[chk_addr_q[i]]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
